multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_comb.sv | 36 +++
 rtl/multicycle_alu.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op-codes and FSM state encoding for the multicycle ALU.
// ALU_Control uses the same op-code constants.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_EQ   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_NA6  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_NAB  = 4'b1011;
    localparam logic [3:0] OP_GE   = 4'b1100;
    localparam logic [3:0] OP_GEU  = 4'b1101;
    localparam logic [3:0] OP_LT   = 4'b1110;
    localparam logic [3:0] OP_LTU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU decode for every non-shift op-code.
// Shift codes and undefined codes yield zero here.
module alu_comb
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;

    // Pure combinational op decode; comparisons produce 0 or 1.
    always_comb begin
        result = ZERO;
        unique case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: result = a + b;
            OP_EQ:  result = (a == b) ? ONE : ZERO;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_SUB: result = a - b;
            OP_GE:  result = ($signed(a) >= $signed(b)) ? ONE : ZERO;
            OP_GEU: result = (a >= b) ? ONE : ZERO;
            OP_LT:  result = ($signed(a) < $signed(b)) ? ONE : ZERO;
            OP_LTU: result = (a < b) ? ONE : ZERO;
            default: result = ZERO;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ops finish in one cycle, shifts
// move one bit position per cycle through a working register.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [3:0]            ALU_OP_i,
    input  logic [DATA_WIDTH-1:0] SRC_A_i,
    input  logic [DATA_WIDTH-1:0] SRC_B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_RESULT_o,
    output logic                  ZERO_o
);

    alu_state_e            state;
    logic [3:0]            shift_op;
    logic [DATA_WIDTH-1:0] work;
    logic [4:0]            cnt;
    logic [DATA_WIDTH-1:0] comb_result;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [4:0]            shamt;

    assign shamt = SRC_B_i[4:0];

    alu_comb #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu_comb (
        .op     (ALU_OP_i),
        .a      (SRC_A_i),
        .b      (SRC_B_i),
        .result (comb_result)
    );

    // One-bit step of the shift in progress; SRA replicates the sign bit.
    always_comb begin
        shift_next = work;
        unique case (shift_op)
            OP_SLL:  shift_next = work << 1;
            OP_SRL:  shift_next = work >> 1;
            OP_SRA:  shift_next = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
            default: shift_next = work;
        endcase
    end

    // Control FSM with working shift register, counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            shift_op     <= OP_AND;
            work         <= '0;
            cnt          <= '0;
            ALU_RESULT_o <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (is_shift_op(ALU_OP_i) && (shamt != 5'd0)) begin
                            shift_op <= ALU_OP_i;
                            work     <= SRC_A_i;
                            cnt      <= shamt;
                            state    <= ST_SHIFT;
                        end else if (is_shift_op(ALU_OP_i)) begin
                            ALU_RESULT_o <= SRC_A_i;
                            state        <= ST_DONE;
                        end else begin
                            ALU_RESULT_o <= comb_result;
                            state        <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= shift_next;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        ALU_RESULT_o <= shift_next;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);
    assign done_o = (state == ST_DONE);
    assign ZERO_o = (ALU_RESULT_o == '0);

endmodule
